uart_tx_cfg: RTL and testbench

UART_TX_CFG -- requirements
Module: uart_tx_cfg

---
 rtl/uart_tx_cfg.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter with a small input FIFO.
// Frames are start bit, DATA_BITS data bits sent LSB first, an optional
// odd/even parity bit, and 1 or 2 stop bits. Back-to-back frames leave no idle gap.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   in_data/in_valid/in_ready - byte push interface into the FIFO
//   tx              - registered serial line, idles high
//   busy            - frame in progress or FIFO non-empty
//   tx_state        - current FSM state (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
//   fifo_count      - occupied FIFO entries
module uart_tx_cfg #(
    parameter int unsigned CLKS_PER_BIT = 234,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [2:0]                    tx_state,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned CNT_W  = $clog2(STOP_BITS * CLKS_PER_BIT);
    localparam int unsigned IDX_W  = 3;

    localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  STOP_END = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_END  = IDX_W'(DATA_BITS - 1);
    localparam logic [FCNT_W-1:0] FULL     = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_q, par_d;
    logic                   tx_q, tx_d;

    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [FCNT_W-1:0]      count_q;
    logic [DATA_BITS-1:0]   head;
    logic                   head_par;
    logic                   push_c, pop_c;
    logic                   bit_done;

    assign in_ready   = (count_q != FULL);
    assign push_c     = in_valid && in_ready;
    assign head       = mem[rd_ptr];
    // Even parity is the XOR of the data bits; odd parity is its inverse.
    assign head_par   = (^head) ^ (PARITY == 1);
    assign bit_done   = (cnt_q == BIT_END);

    assign tx         = tx_q;
    assign tx_state   = state_q;
    assign fifo_count = count_q;
    assign busy       = (state_q != S_IDLE) || (count_q != '0);

    // Next-state, bit timing, shift register and next tx level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        pop_c   = 1'b0;
        tx_d    = 1'b1;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (count_q != '0) begin
                    pop_c   = 1'b1;
                    shreg_d = head;
                    par_d   = head_par;
                    state_d = S_START;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_d = shreg_q[0];
                if (bit_done) begin
                    cnt_d   = '0;
                    shreg_d = shreg_q >> 1;
                    if (idx_q == IDX_END) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: begin
                tx_d = par_q;
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                // Stop time spans all stop bits in one count.
                if (cnt_q == STOP_END) begin
                    cnt_d = '0;
                    if (count_q != '0) begin
                        pop_c   = 1'b1;
                        shreg_d = head;
                        par_d   = head_par;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and transmit datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + FCNT_W'(1);
                2'b01:   count_q <= count_q - FCNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage.
    always_ff @(posedge clk) begin
        if (push_c && !rst) mem[wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed testbench for uart_tx_cfg with CLKS_PER_BIT=4.
// Instances: 0=8N1, 1=8E1, 2=8O1, 3=8O2, 4=7N1 (all FIFO_DEPTH=4).
module tb_uart_tx_cfg;

    logic       clk;
    logic       rst;
    logic [7:0] d8;
    logic [6:0] d7;
    logic [4:0] iv;
    logic [4:0] rdy, txs, bsy;
    logic [2:0] st [5];
    logic [2:0] fc [5];

    int errors = 0;
    int checks = 0;

    logic w_tx   [0:255];
    logic w_busy [0:255];

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .in_data(d8), .in_valid(iv[0]), .in_ready(rdy[0]),
        .tx(txs[0]), .busy(bsy[0]), .tx_state(st[0]), .fifo_count(fc[0]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .in_data(d8), .in_valid(iv[1]), .in_ready(rdy[1]),
        .tx(txs[1]), .busy(bsy[1]), .tx_state(st[1]), .fifo_count(fc[1]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .in_data(d8), .in_valid(iv[2]), .in_ready(rdy[2]),
        .tx(txs[2]), .busy(bsy[2]), .tx_state(st[2]), .fifo_count(fc[2]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .in_data(d8), .in_valid(iv[3]), .in_ready(rdy[3]),
        .tx(txs[3]), .busy(bsy[3]), .tx_state(st[3]), .fifo_count(fc[3]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u4 (
        .clk(clk), .rst(rst), .in_data(d7), .in_valid(iv[4]), .in_ready(rdy[4]),
        .tx(txs[4]), .busy(bsy[4]), .tx_state(st[4]), .fifo_count(fc[4]));

    always #5 clk = ~clk;

    // Push one byte into instance 'which' and record tx/busy for n cycles.
    // Index 0 is sampled just after the push edge, so start bit spans 2..5.
    task automatic capture(input int which, input logic [7:0] data, input int n);
        @(negedge clk);
        d8 = data;
        d7 = data[6:0];
        iv[which] = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) iv = '0;
            w_tx[i]   = txs[which];
            w_busy[i] = bsy[which];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        iv  = '0;
        d8  = '0;
        d7  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (txs !== 5'b11111) begin errors++; $display("FAIL reset_tx: got %b want 11111", txs); end
        checks++;
        if (st[0] !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", st[0]); end
        checks++;
        if (fc[0] !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fc[0]); end
        checks++;
        if (rdy[0] !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy[0]); end
        checks++;
        if (bsy !== 5'b00000) begin errors++; $display("FAIL reset_busy: got %b want 00000", bsy); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (txs !== 5'b11111 || bsy !== 5'b00000) begin
            errors++; $display("FAIL post_reset_idle: tx=%b busy=%b want 11111/00000", txs, bsy);
        end
    endtask

    task automatic test_8n1();
        logic [9:0] fb;
        logic [3:0] obs;
        fb = {1'b1, 8'hA5, 1'b0};
        capture(0, 8'hA5, 44);
        checks++;
        if (w_tx[1] !== 1'b1) begin errors++; $display("FAIL 8n1_start_latency: tx[1]=%b want 1", w_tx[1]); end
        for (int k = 0; k < 10; k++) begin
            obs = {w_tx[2+4*k], w_tx[3+4*k], w_tx[4+4*k], w_tx[5+4*k]};
            checks++;
            if (obs !== {4{fb[k]}}) begin
                errors++; $display("FAIL 8n1_bit%0d: got %b want %b", k, obs, {4{fb[k]}});
            end
        end
        checks++;
        if (w_busy[40] !== 1'b1 || w_busy[41] !== 1'b0) begin
            errors++; $display("FAIL 8n1_frame_len: busy[40]=%b busy[41]=%b want 1/0", w_busy[40], w_busy[41]);
        end
        checks++;
        if (st[0] !== 3'd0 || w_tx[43] !== 1'b1) begin
            errors++; $display("FAIL 8n1_end_idle: state=%0d tx=%b want 0/1", st[0], w_tx[43]);
        end
    endtask

    task automatic test_parity();
        logic       p;
        int         len;
        logic [7:0] got;
        logic [3:0] pw;
        logic [7:0] sw;
        for (int j = 1; j <= 3; j++) begin
            p   = (j == 1) ? 1'b0 : 1'b1;
            len = (j == 3) ? 48 : 44;
            capture(j, 8'hA5, 52);
            for (int k = 0; k < 8; k++) got[k] = w_tx[7+4*k];
            checks++;
            if (got !== 8'hA5 || w_tx[3] !== 1'b0) begin
                errors++; $display("FAIL par%0d_data: got %h start=%b want a5/0", j, got, w_tx[3]);
            end
            pw = {w_tx[38], w_tx[39], w_tx[40], w_tx[41]};
            checks++;
            if (pw !== {4{p}}) begin
                errors++; $display("FAIL par%0d_bit: got %b want %b", j, pw, {4{p}});
            end
            checks++;
            if (w_busy[len] !== 1'b1 || w_busy[len+1] !== 1'b0) begin
                errors++; $display("FAIL par%0d_frame_len: busy[%0d]=%b busy[%0d]=%b want 1/0",
                                   j, len, w_busy[len], len+1, w_busy[len+1]);
            end
            if (j == 3) begin
                for (int k = 0; k < 8; k++) sw[k] = w_tx[42+k];
                checks++;
                if (sw !== 8'hFF) begin errors++; $display("FAIL par3_two_stop: got %b want 11111111", sw); end
            end
        end
    endtask

    task automatic test_7bit();
        logic [27:0] dw;
        capture(4, 8'h7F, 40);
        for (int k = 0; k < 28; k++) dw[k] = w_tx[6+k];
        checks++;
        if ({w_tx[2], w_tx[5]} !== 2'b00 || dw !== 28'hFFFFFFF) begin
            errors++; $display("FAIL 7bit_data: start=%b%b data=%h want 00/fffffff", w_tx[2], w_tx[5], dw);
        end
        checks++;
        if (w_busy[36] !== 1'b1 || w_busy[37] !== 1'b0) begin
            errors++; $display("FAIL 7bit_frame_len: busy[36]=%b busy[37]=%b want 1/0", w_busy[36], w_busy[37]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h3C, 8'h81, 8'hF0};
        logic [7:0] got;
        @(negedge clk);
        d8 = bytes[0];
        iv[0] = 1'b1;
        for (int i = 0; i < 210; i++) begin
            @(negedge clk);
            w_tx[i]   = txs[0];
            w_busy[i] = bsy[0];
            if (i < 4) d8 = bytes[i+1];
            if (i == 4) begin
                checks++;
                if (fc[0] !== 3'd4 || rdy[0] !== 1'b0) begin
                    errors++; $display("FAIL b2b_full: count=%0d ready=%b want 4/0", fc[0], rdy[0]);
                end
                d8 = 8'h66;
            end
            if (i == 20) begin
                checks++;
                if (fc[0] !== 3'd4 || rdy[0] !== 1'b0) begin
                    errors++; $display("FAIL b2b_refused: count=%0d ready=%b want 4/0", fc[0], rdy[0]);
                end
                iv[0] = 1'b0;
            end
            if (i == 40) begin
                checks++;
                if (rdy[0] !== 1'b0) begin errors++; $display("FAIL b2b_ready_hold: got %b want 0", rdy[0]); end
            end
            if (i == 41) begin
                checks++;
                if (fc[0] !== 3'd3 || rdy[0] !== 1'b1) begin
                    errors++; $display("FAIL b2b_first_pop: count=%0d ready=%b want 3/1", fc[0], rdy[0]);
                end
            end
        end
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < 8; k++) got[k] = w_tx[7+40*f+4*k];
            checks++;
            if (got !== bytes[f] || w_tx[2+40*f] !== 1'b0 || w_tx[41+40*f] !== 1'b1) begin
                errors++; $display("FAIL b2b_frame%0d: got %h start=%b stop=%b want %h/0/1",
                                   f, got, w_tx[2+40*f], w_tx[41+40*f], bytes[f]);
            end
        end
        checks++;
        if (w_busy[200] !== 1'b1 || w_busy[201] !== 1'b0) begin
            errors++; $display("FAIL b2b_total_len: busy[200]=%b busy[201]=%b want 1/0", w_busy[200], w_busy[201]);
        end
    endtask

    task automatic test_push_pop();
        logic [7:0] got;
        logic [7:0] exp_b [2] = '{8'h3C, 8'hC3};
        @(negedge clk);
        d8 = 8'h3C;
        iv[0] = 1'b1;
        for (int i = 0; i < 86; i++) begin
            @(negedge clk);
            w_tx[i]   = txs[0];
            w_busy[i] = bsy[0];
            if (i == 0) begin
                checks++;
                if (fc[0] !== 3'd1) begin errors++; $display("FAIL pp_first_push: count=%0d want 1", fc[0]); end
                d8 = 8'hC3;
            end
            if (i == 1) begin
                checks++;
                if (fc[0] !== 3'd1 || st[0] !== 3'd1) begin
                    errors++; $display("FAIL pp_same_edge: count=%0d state=%0d want 1/1", fc[0], st[0]);
                end
                iv[0] = 1'b0;
            end
        end
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) got[k] = w_tx[7+40*f+4*k];
            checks++;
            if (got !== exp_b[f]) begin
                errors++; $display("FAIL pp_order%0d: got %h want %h", f, got, exp_b[f]);
            end
        end
        checks++;
        if (w_busy[80] !== 1'b1 || w_busy[81] !== 1'b0) begin
            errors++; $display("FAIL pp_len: busy[80]=%b busy[81]=%b want 1/0", w_busy[80], w_busy[81]);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        @(negedge clk);
        d8 = 8'h04;
        iv[0] = 1'b1;
        for (int i = 0; i < 117; i++) begin
            @(negedge clk);
            if (i == 0) d8 = 8'h55;
            if (i == 1) d8 = 8'hAA;
            if (i == 2) begin
                iv[0] = 1'b0;
                checks++;
                if (fc[0] !== 3'd2) begin errors++; $display("FAIL rm_queued: count=%0d want 2", fc[0]); end
            end
            if (i == 15) begin
                // Third data bit of 0x04 is a 1; rst collides with a push.
                checks++;
                if (txs[0] !== 1'b1 || st[0] !== 3'd2) begin
                    errors++; $display("FAIL rm_in_bit2: tx=%b state=%0d want 1/2", txs[0], st[0]);
                end
                rst   = 1'b1;
                d8    = 8'hFF;
                iv[0] = 1'b1;
            end
            if (i == 16) begin
                checks++;
                if (txs[0] !== 1'b1 || fc[0] !== 3'd0 || st[0] !== 3'd0 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
                    errors++; $display("FAIL rm_after_rst: tx=%b count=%0d state=%0d busy=%b ready=%b want 1/0/0/0/1",
                                       txs[0], fc[0], st[0], bsy[0], rdy[0]);
                end
                rst   = 1'b0;
                iv[0] = 1'b0;
            end
            if (i > 16 && (txs[0] !== 1'b1 || bsy[0] !== 1'b0)) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rm_quiet: %0d active cycles want 0", bad); end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        iv  = '0;
        d8  = '0;
        d7  = '0;
        test_reset();
        test_8n1();
        test_parity();
        test_7bit();
        test_back_to_back();
        test_push_pop();
        test_reset_mid();
        test_8n1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
